// File: rtl/circle_draw.sv
// Midpoint circle rasteriser: one pixel per clock onto the framebuffer plot bus.
// Off-screen pixels keep their slot in the sequence but have the strobe dropped.
module circle_draw #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic [2:0] colour,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {
    IDLE,
    PLOT,
    UPDATE,
    FIN
  } state_t;

  localparam logic signed [10:0] W_S = 11'(SCREEN_W);
  localparam logic signed [10:0] H_S = 11'(SCREEN_H);

  state_t             state;
  logic        [7:0]  cx;
  logic        [6:0]  cy;
  logic signed [10:0] ox;
  logic signed [10:0] oy;
  logic signed [11:0] crit;
  logic        [2:0]  oct;

  logic signed [10:0] ox_n;
  logic signed [10:0] oy_n;
  logic signed [11:0] crit_n;
  logic signed [10:0] dxy;

  logic        [2:0]  e_oct;
  logic signed [10:0] e_ox;
  logic signed [10:0] e_oy;
  logic signed [10:0] e_cx;
  logic signed [10:0] e_cy;
  logic signed [10:0] ex;
  logic signed [10:0] ey;
  logic               e_vis;

  function automatic logic signed [10:0] oct_x(
    input logic        [2:0]  o,
    input logic signed [10:0] a,
    input logic signed [10:0] b,
    input logic signed [10:0] c
  );
    logic signed [10:0] r;
    unique case (o)
      3'd0, 3'd6: r = c + a;
      3'd1, 3'd7: r = c + b;
      3'd2, 3'd4: r = c - a;
      default:    r = c - b;
    endcase
    return r;
  endfunction

  function automatic logic signed [10:0] oct_y(
    input logic        [2:0]  o,
    input logic signed [10:0] a,
    input logic signed [10:0] b,
    input logic signed [10:0] c
  );
    logic signed [10:0] r;
    unique case (o)
      3'd0, 3'd2: r = c + b;
      3'd1, 3'd3: r = c + a;
      3'd4, 3'd6: r = c - b;
      default:    r = c - a;
    endcase
    return r;
  endfunction

  // Decision-variable step for the next row
  always_comb begin
    oy_n   = oy + 11'sd1;
    ox_n   = ox;
    dxy    = '0;
    crit_n = crit + $signed({oy_n, 1'b0}) + 12'sd1;
    if (crit > 12'sd0) begin
      ox_n   = ox - 11'sd1;
      dxy    = oy_n - ox_n;
      crit_n = crit + $signed({dxy, 1'b0}) + 12'sd1;
    end
  end

  // Pixel to present in the next cycle
  always_comb begin
    e_oct = oct + 3'd1;
    e_ox  = ox;
    e_oy  = oy;
    e_cx  = $signed({3'b0, cx});
    e_cy  = $signed({4'b0, cy});
    unique case (state)
      IDLE: begin
        e_oct = 3'd0;
        e_ox  = $signed({3'b0, radius});
        e_oy  = '0;
        e_cx  = $signed({3'b0, centre_x});
        e_cy  = $signed({4'b0, centre_y});
      end
      UPDATE: begin
        e_oct = 3'd0;
        e_ox  = ox_n;
        e_oy  = oy_n;
      end
      default: ;
    endcase
    ex    = oct_x(e_oct, e_ox, e_oy, e_cx);
    ey    = oct_y(e_oct, e_ox, e_oy, e_cy);
    e_vis = !ex[10] && (ex < W_S) && !ey[10] && (ey < H_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
      oct        <= '0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (start) begin
            cx         <= centre_x;
            cy         <= centre_y;
            ox         <= $signed({3'b0, radius});
            oy         <= '0;
            crit       <= 12'sd1 - $signed({4'b0, radius});
            oct        <= 3'd0;
            vga_colour <= colour;
            vga_x      <= ex[7:0];
            vga_y      <= ey[6:0];
            vga_plot   <= e_vis;
            state      <= PLOT;
          end
        end
        PLOT: begin
          if (oct == 3'd7) begin
            vga_plot <= 1'b0;
            state    <= UPDATE;
          end else begin
            oct      <= e_oct;
            vga_x    <= ex[7:0];
            vga_y    <= ey[6:0];
            vga_plot <= e_vis;
          end
        end
        UPDATE: begin
          ox   <= ox_n;
          oy   <= oy_n;
          crit <= crit_n;
          if (oy_n <= ox_n) begin
            oct      <= 3'd0;
            vga_x    <= ex[7:0];
            vga_y    <= ey[6:0];
            vga_plot <= e_vis;
            state    <= PLOT;
          end else begin
            vga_plot <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          vga_plot <= 1'b0;
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_draw.sv
// Bench for circle_draw: per-cycle comparison against a software
// midpoint model, plus reset, handshake, clipping and radius-0 cases.
module tb_circle_draw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [2:0] colour;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_cmp = 0;
  int n_bad = 0;
  int qx[$];
  int qy[$];
  int qp[$];
  int qk[$];

  always #5 clk = ~clk;

  circle_draw dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .centre_x  (centre_x),
    .centre_y  (centre_y),
    .radius    (radius),
    .colour    (colour),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected bus contents per cycle: 8 symmetric points then an idle slot
  task automatic build(input int cx, input int cy, input int r);
    int x, y, d, px, py;
    int ax[8];
    int ay[8];
    qx.delete(); qy.delete(); qp.delete(); qk.delete();
    x = r; y = 0; d = 1 - r;
    do begin
      ax = '{x, y, -x, -y, -x, -y, x, y};
      ay = '{y, x, y, x, -y, -x, -y, -x};
      for (int k = 0; k < 8; k++) begin
        px = cx + ax[k];
        py = cy + ay[k];
        qx.push_back(px & 255);
        qy.push_back(py & 127);
        qp.push_back((px >= 0 && px < 160 && py >= 0 && py < 120) ? 1 : 0);
        qk.push_back(1);
      end
      qx.push_back(0); qy.push_back(0); qp.push_back(0); qk.push_back(0);
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end while (y <= x);
  endtask

  task automatic run_draw(input int cx, input int cy, input int r,
                          input int col, input bit mutate, input int hold);
    build(cx, cy, r);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 8'(r);
    colour   = 3'(col);
    start    = 1'b1;
    tick;
    foreach (qk[i]) begin
      if (qk[i] != 0) begin
        chk("pix_x", vga_x, qx[i]);
        chk("pix_y", vga_y, qy[i]);
        chk("pix_plot", vga_plot, qp[i]);
        chk("pix_colour", vga_colour, col);
      end else begin
        chk("upd_plot", vga_plot, 0);
      end
      chk("busy_done", done, 0);
      if (mutate && i == 3) begin
        centre_x = 8'($urandom);
        centre_y = 7'($urandom);
        radius   = 8'($urandom);
        colour   = 3'($urandom);
      end
      tick;
    end
    chk("done_rise", done, 1);
    chk("done_plot", vga_plot, 0);
    repeat (hold) begin
      tick;
      chk("hold_done", done, 1);
      chk("hold_plot", vga_plot, 0);
    end
    start = 1'b0;
    tick;
    chk("done_fall", done, 0);
    chk("idle_plot", vga_plot, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    centre_x = '0;
    centre_y = '0;
    radius   = '0;
    colour   = '0;
    #12;
    chk("rst_done", done, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_done", done, 0);

    // Abort in the 5th pixel cycle
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10; colour = 3'd4;
    start = 1'b1;
    tick;
    repeat (4) tick;
    chk("pre_abort_plot", vga_plot, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_plot", vga_plot, 0);
    chk("abort_done", done, 0);
    chk("abort_x", vga_x, 0);
    chk("abort_y", vga_y, 0);
    chk("abort_colour", vga_colour, 0);
    start = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (5) begin
      tick;
      chk("post_abort_plot", vga_plot, 0);
      chk("post_abort_done", done, 0);
    end

    run_draw(80, 60, 10, 4, 1'b0, 3);
    run_draw(80, 60, 10, 4, 1'b0, 0);
    run_draw(0, 0, 5, 2, 1'b0, 1);
    run_draw(10, 10, 0, 7, 1'b0, 1);
    run_draw(159, 119, 20, 5, 1'b1, 0);
    repeat (6) begin
      run_draw(int'($urandom_range(255)), int'($urandom_range(127)),
               int'($urandom_range(40)), int'($urandom_range(7)), 1'b1,
               int'($urandom_range(2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/circle_draw.md
Name: circle_draw

Overview:
- Midpoint (Bresenham) circle rasteriser that generates one pixel per clock on the plot interface consumed by the VGA adapter framebuffer.
- It is the draw stage run after the screen-fill engine has cleared the screen. It shares the same pixel-bus format and start/done handshake.
- Pixels outside the visible screen are suppressed by deasserting the plot strobe. The raster sequence and cycle count are unchanged by clipping.

Parameters:
- SCREEN_W, 160, visible width in pixels; valid x is 0..SCREEN_W-1.
- SCREEN_H, 120, visible height in pixels; valid y is 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- centre_x  in  8  circle centre x; latched at start.
- centre_y  in  7  circle centre y; latched at start.
- radius  in  8  circle radius; latched at start.
- colour  in  3  pixel colour; latched at start.
- done  out  1  high when the circle is complete; held until start falls.
- vga_x  out  8  pixel x (low 8 bits of the signed coordinate).
- vga_y  out  7  pixel y (low 7 bits of the signed coordinate).
- vga_colour  out  3  latched colour.
- vga_plot  out  1  write strobe for the current pixel.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done, vga_plot, vga_x, vga_y and vga_colour all 0. Reset mid-draw aborts immediately, with no further plots.
- States are IDLE, PLOT, UPDATE and DONE.
- IDLE: when start=1 is seen at an edge:
  - latch centre_x, centre_y, radius and colour;
  - set ox=radius, oy=0, crit=1-radius (signed, at least 10 bits);
  - set octant=0 and go to PLOT.
- PLOT: one pixel per cycle for octant 0..7. The order is:
  - 0:(cx+ox, cy+oy)
  - 1:(cx+oy, cy+ox)
  - 2:(cx-ox, cy+oy)
  - 3:(cx-oy, cy+ox)
  - 4:(cx-ox, cy-oy)
  - 5:(cx-oy, cy-ox)
  - 6:(cx+ox, cy-oy)
  - 7:(cx+oy, cy-ox)
- After octant 7 the next state is UPDATE.
- Arithmetic: coordinates are computed signed, at least 10 bits wide.
  - vga_plot=1 only if 0<=x<SCREEN_W and 0<=y<SCREEN_H; otherwise vga_plot=0.
  - vga_x and vga_y always carry the truncated low bits.
- UPDATE: one cycle with vga_plot=0.
  - oy=oy+1.
  - If crit<=0: crit=crit+2*oy_new+1.
  - Else: ox=ox-1 and crit=crit+2*(oy_new-ox_new)+1.
  - Then, if oy_new<=ox_new, go to PLOT with octant=0; otherwise go to DONE.
- DONE: done=1 and vga_plot=0.
  - Stay while start=1; go to IDLE when start=0.
  - done falls on the cycle IDLE is entered.
- Timing: if start is sampled at edge E0, the first pixel is valid in the cycle after E0. Each iteration is exactly 9 cycles (8 PLOT + 1 UPDATE). done rises in the cycle after the final UPDATE.
- start changes and input changes while in PLOT or UPDATE are ignored, because all inputs are latched.
- radius=0: one iteration of 8 identical pixels at the centre, then DONE. Duplicate pixels are permitted.
- Pixels on octant boundaries may be plotted twice; this is allowed.
- vga_colour holds the latched colour from start until the next start.

Test Plan:
- Reset during draw: rst_n low in the 5th pixel cycle -> vga_plot=0, done=0 and outputs 0 immediately. After release with start=0, the block stays idle and done=0.
- centre (80,60), r=10, colour=3'b100, start at edge E0:
  - cycle 1 shows vga_x=90, vga_y=60, plot=1, colour=4; cycle 2 shows (80,70).
  - exactly 8 iterations (64 PLOT + 8 UPDATE cycles); done=1 at cycle 73.
  - the last iteration's pixel 0 is (87,67).
- Handshake: hold start=1 through completion -> done stays 1 and no new draw begins. Drop start -> done=0 next cycle; raise start again -> the redraw repeats the identical sequence.
- Clipping: centre (0,0), r=5 -> octant 0 gives (5,0) with plot=1, octant 2 gives x=-5 with plot=0. The total cycle count equals the unclipped case, and no plot=1 occurs with y outside 0..119.
- radius=0 at centre (10,10) -> 8 cycles of (10,10) with plot=1, 1 UPDATE cycle, done at cycle 10.
- Input stability: change centre, radius and colour mid-draw -> the pixel stream is unaffected; the golden sequence is checked against a software midpoint model.
